// File: rtl/program_bus_sequencer_pkg.sv
// program_bus_pkg: sequencer T-states, opcodes and bus-source encoding for program_bus_sequencer.
package program_bus_pkg;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } t_state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_MEM  = 3'd2,
        BUS_OPND = 3'd3,
        BUS_ACC  = 3'd4,
        BUS_USER = 3'd5
    } bus_sel_e;

endpackage

// File: rtl/program_bus_sequencer_if.sv
// program_bus_sequencer_if: user load port and processor-state outputs; FLAGS_EN adds carry/zero flags.
interface program_bus_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              op;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] user_address;
    logic              write_memory;
    logic [DATA_W-1:0] bus_out;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] out_reg;
    logic [2:0]        t_state;
    logic              halted;
`ifdef FLAGS_EN
    logic              carry_flag;
    logic              zero_flag;
`endif

    modport master (
        output op, data_in, user_address, write_memory,
`ifdef FLAGS_EN
        input carry_flag, zero_flag,
`endif
        input bus_out, pc, ir, acc, out_reg, t_state, halted
    );

    modport slave (
        input op, data_in, user_address, write_memory,
`ifdef FLAGS_EN
        output carry_flag, zero_flag,
`endif
        output bus_out, pc, ir, acc, out_reg, t_state, halted
    );
endinterface

// File: rtl/program_bus_sequencer_ram.sv
// program_ram: 2**ADDR_W x DATA_W program/data RAM, asynchronous read, one synchronous write port.
module program_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];
endmodule

// File: rtl/program_bus_sequencer.sv
// program_bus_sequencer: program RAM, shared bus and T0-T4 fetch/execute sequencer with accumulator.
// FLAGS_EN enables carry/zero flags and the JC/JZ conditional jumps.
module program_bus_sequencer
    import program_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic                     clk,
    input logic                     reset,
    program_bus_sequencer_if.slave  bus
);
    localparam int OP_W = DATA_W - ADDR_W;

    t_state_e          state, state_n;
    bus_sel_e          sel;
    logic [ADDR_W-1:0] pc, pc_n, mar, mar_n, wa, ra;
    logic [DATA_W-1:0] ir, ir_n, acc, acc_n, out_r, out_n, wd, rd;
    logic              we;
    logic [OP_W-1:0]   opf;
    logic [3:0]        opc;
    logic [ADDR_W-1:0] opnd;
    logic              mem_op;

    assign opf    = ir[DATA_W-1:ADDR_W];
    assign opnd   = ir[ADDR_W-1:0];
    // opcode fields wider than 4 bits only decode when the extra bits are zero
    assign opc    = ((opf >> 4) != '0) ? OP_NOP : opf[3:0];
    assign mem_op = (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_STA);

`ifdef FLAGS_EN
    logic              carry, carry_n, zero, zero_n;
    logic [DATA_W:0]   add_r, sub_r;
    assign add_r = {1'b0, acc} + {1'b0, rd};
    // two's-complement subtract: the carry-out is the no-borrow flag
    assign sub_r = {1'b0, acc} + {1'b0, ~rd} + {{DATA_W{1'b0}}, 1'b1};
`else
    logic [DATA_W-1:0] add_r, sub_r;
    assign add_r = acc + rd;
    assign sub_r = acc - rd;
`endif

    program_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk(clk), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= T0;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        mar_n   = mar;
        ir_n    = ir;
        acc_n   = acc;
        out_n   = out_r;
`ifdef FLAGS_EN
        carry_n = carry;
        zero_n  = zero;
`endif
        sel     = BUS_NONE;
        we      = 1'b0;
        wa      = bus.user_address;
        wd      = bus.data_in;
        ra      = mar;
        if (!bus.op) begin
            state_n = T0;
            pc_n    = '0;
            we      = bus.write_memory;
            ra      = bus.user_address;
            sel     = BUS_USER;
        end else begin
            case (state)
                T0: begin
                    mar_n   = pc;
                    state_n = T1;
                    sel     = BUS_PC;
                end
                T1: begin
                    ir_n    = rd;
                    state_n = T2;
                    sel     = BUS_MEM;
                end
                T2: begin
                    pc_n    = pc + 1'b1;
                    state_n = (opc == OP_HLT) ? HALT : T3;
                end
                T3: begin
                    state_n = T4;
                    mar_n   = mem_op ? opnd : mar;
                    sel     = mem_op ? BUS_OPND : BUS_NONE;
                end
                T4: begin
                    state_n = T0;
                    case (opc)
                        OP_LDA: begin
                            acc_n = rd;
                            sel   = BUS_MEM;
                        end
                        OP_ADD: begin
                            acc_n = add_r[DATA_W-1:0];
                            sel   = BUS_MEM;
`ifdef FLAGS_EN
                            carry_n = add_r[DATA_W];
                            zero_n  = (add_r[DATA_W-1:0] == '0);
`endif
                        end
                        OP_SUB: begin
                            acc_n = sub_r[DATA_W-1:0];
                            sel   = BUS_MEM;
`ifdef FLAGS_EN
                            carry_n = sub_r[DATA_W];
                            zero_n  = (sub_r[DATA_W-1:0] == '0);
`endif
                        end
                        OP_STA: begin
                            we  = 1'b1;
                            wa  = mar;
                            wd  = acc;
                            sel = BUS_ACC;
                        end
                        OP_JMP: begin
                            pc_n = opnd;
                            sel  = BUS_OPND;
                        end
`ifdef FLAGS_EN
                        OP_JC: begin
                            pc_n = carry ? opnd : pc;
                            sel  = carry ? BUS_OPND : BUS_NONE;
                        end
                        OP_JZ: begin
                            pc_n = zero ? opnd : pc;
                            sel  = zero ? BUS_OPND : BUS_NONE;
                        end
`endif
                        OP_OUT: begin
                            out_n = acc;
                            sel   = BUS_ACC;
                        end
                        default: ;
                    endcase
                end
                default: state_n = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc    <= '0;
            mar   <= '0;
            ir    <= '0;
            acc   <= '0;
            out_r <= '0;
`ifdef FLAGS_EN
            carry <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            pc    <= pc_n;
            mar   <= mar_n;
            ir    <= ir_n;
            acc   <= acc_n;
            out_r <= out_n;
`ifdef FLAGS_EN
            carry <= carry_n;
            zero  <= zero_n;
`endif
        end

    assign bus.bus_out = (sel == BUS_PC)                       ? DATA_W'(pc)   :
                         (sel == BUS_MEM || sel == BUS_USER)   ? rd            :
                         (sel == BUS_OPND)                     ? DATA_W'(opnd) :
                         (sel == BUS_ACC)                      ? acc           : '0;
    assign bus.pc      = pc;
    assign bus.ir      = ir;
    assign bus.acc     = acc;
    assign bus.out_reg = out_r;
    assign bus.t_state = state;
    assign bus.halted  = (state == HALT);
`ifdef FLAGS_EN
    assign bus.carry_flag = carry;
    assign bus.zero_flag  = zero;
`endif
endmodule

// File: tb/tb_program_bus_sequencer.sv
// tb_program_bus_sequencer: scoreboard bench for load, run, STA/SUB wrap, JMP wrap, abort and async reset.
module tb_program_bus_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        string       tag;
        int          id;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    program_bus_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bif ();

    program_bus_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sig(input int id);
        case (id)
            0: return 32'(bif.bus_out);
            1: return 32'(bif.pc);
            2: return 32'(bif.ir);
            3: return 32'(bif.acc);
            4: return 32'(bif.out_reg);
            5: return 32'(bif.t_state);
            6: return 32'(bif.halted);
`ifdef FLAGS_EN
            7: return 32'(bif.carry_flag);
            8: return 32'(bif.zero_flag);
`endif
            default: return 32'hDEAD;
        endcase
    endfunction

    task automatic push(input string tag, input int id, input logic [31:0] exp);
        sbq.push_back('{tag, id, exp});
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, sig(e.id), e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bif.op = 1'b0;
        bif.user_address = a;
        bif.data_in = d;
        bif.write_memory = 1'b1;
        step(1);
        bif.write_memory = 1'b0;
    endtask

    task automatic rb(input string tag, input logic [3:0] a, input logic [7:0] d);
        bif.op = 1'b0;
        bif.user_address = a;
        #1;
        push(tag, 0, 32'(d));
        drain();
    endtask

    logic [7:0] prog1 [6] = '{8'h14, 8'h25, 8'hE0, 8'hF0, 8'h07, 8'h03};
    logic [7:0] prog2 [6] = '{8'h14, 8'h35, 8'h46, 8'hF0, 8'h03, 8'h07};

    initial begin
        bif.op = 1'b0;
        bif.data_in = '0;
        bif.user_address = '0;
        bif.write_memory = 1'b0;
        reset = 1'b1;
        step(2);
        push("rst_pc", 1, 0); push("rst_ir", 2, 0); push("rst_acc", 3, 0);
        push("rst_out", 4, 0); push("rst_t", 5, 0); push("rst_halt", 6, 0);
`ifdef FLAGS_EN
        push("rst_c", 7, 0); push("rst_z", 8, 0);
`endif
        drain();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) wr(4'(i), prog1[i]);
        for (int i = 0; i < 6; i++) rb("load_rb", 4'(i), prog1[i]);

        bif.op = 1'b1;
        #1;
        push("run_t0_bus", 0, 0);
        drain();
        step(15);
        push("run_out", 4, 8'h0A);
        drain();
        step(3);
        push("run_halt", 6, 1); push("run_pc", 1, 4); push("run_acc", 3, 8'h0A);
        push("run_t_halt", 5, 5);
        drain();
        step(6);
        push("hold_halt", 6, 1); push("hold_pc", 1, 4); push("hold_out", 4, 8'h0A);
        drain();

        for (int i = 0; i < 6; i++) wr(4'(i), prog2[i]);
        push("prog_clr_halt", 6, 0); push("prog_pc", 1, 0);
        drain();
        bif.op = 1'b1;
        step(18);
        push("sub_halt", 6, 1); push("sub_acc", 3, 8'hFC);
`ifdef FLAGS_EN
        push("sub_carry", 7, 0); push("sub_zero", 8, 0);
`endif
        drain();
        rb("sta_mem6", 4'd6, 8'hFC);

        for (int i = 0; i < 15; i++) wr(4'(i), 8'h00);
        wr(4'd15, 8'h60);
        bif.op = 1'b1;
        step(75);
        push("jmp_t0_pc_bus", 0, 8'h0F);
        drain();
        step(1);
        push("jmp_t1_bus", 0, 8'h60);
        drain();
        step(1);
        push("jmp_ir", 2, 8'h60); push("jmp_pc15", 1, 15);
        drain();
        step(1);
        push("jmp_wrap_pc", 1, 0); push("jmp_wrap_t", 5, 3);
        drain();
        step(2);
        push("jmp_pc_after", 1, 0); push("jmp_t_after", 5, 0);
        drain();

        wr(4'd0, 8'h14);
        wr(4'd4, 8'h55);
        bif.op = 1'b1;
        bif.user_address = 4'd4;
        bif.data_in = 8'hAA;
        bif.write_memory = 1'b1;
        step(3);
        push("abort_at_t3", 5, 3);
        drain();
        bif.write_memory = 1'b0;
        bif.op = 1'b0;
        step(1);
        push("abort_t", 5, 0); push("abort_pc", 1, 0); push("abort_acc", 3, 8'hFC);
        drain();
        rb("abort_mem4", 4'd4, 8'h55);

        for (int i = 0; i < 6; i++) wr(4'(i), prog1[i]);
        bif.op = 1'b1;
        step(14);
        push("pre_rst_t4", 5, 4); push("pre_rst_acc", 3, 8'h0A);
        drain();
        #2;
        reset = 1'b1;
        #1;
        push("async_acc", 3, 0); push("async_out", 4, 0); push("async_pc", 1, 0);
        push("async_ir", 2, 0); push("async_t", 5, 0); push("async_halt", 6, 0);
        push("async_bus", 0, 0);
        drain();
        bif.op = 1'b0;
        step(1);
        reset = 1'b0;
        rb("rst_keep_mem0", 4'd0, 8'h14);
        rb("rst_keep_mem2", 4'd2, 8'hE0);
        rb("rst_keep_mem5", 4'd5, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
